// File: rtl/uart_mon_pkg.sv
// Shared types and helpers for the UART line monitor.
package uart_mon_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } uart_state_e;

    function automatic int unsigned calc_div(input int unsigned clkHz, input int unsigned baud);
        return clkHz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO; full/empty are derived from the occupancy counter.
module sync_fifo
    import uart_mon_pkg::*;
#(
    parameter int WIDTH = BYTE_W,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign doPop   = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign doPush  = push_i && (!full_o || doPop);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rdPtr_q];

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (doPush && !doPop) begin
            count_d = count_q + 1'b1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_tx_monitor.sv
// 8N1 UART receiver that buffers decoded bytes into a FIFO and flags framing
// errors and dropped bytes.
module uart_tx_monitor
    import uart_mon_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12_500_000,
    parameter int unsigned BAUD        = 115200,
    parameter int          FIFO_DEPTH  = 16
) (
    input  logic                              clk,
    input  logic                              rstn,
    input  logic                              i_rx,
    output logic [BYTE_W-1:0]                 o_data,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic                              o_frame_err,
    output logic                              o_overflow,
    input  logic                              i_clr,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_count
);

    localparam int unsigned DIV   = calc_div(CLK_FREQ_HZ, BAUD);
    localparam int          CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    uart_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        idx_q, idx_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              rxMeta_q, rxSync_q;
    logic              frameErr_q, frameErr_d;
    logic              overflow_q, overflow_d;
    logic              push;
    logic              pop;
    logic              fifoFull;
    logic              fifoEmpty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 1'b1;
        idx_d      = idx_q;
        shift_d    = shift_q;
        push       = 1'b0;
        frameErr_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rxSync_q) begin
                    state_d = START;
                end
            end
            START: begin
                // Re-check the start bit at its middle to reject line glitches.
                if (cnt_q == CNT_HALF) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxSync_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxSync_q;
                    idx_d          = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (rxSync_q) begin
                        push    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frameErr_d = 1'b1;
                        state_d    = BREAK;
                    end
                end
            end
            BREAK: begin
                cnt_d = '0;
                if (rxSync_q) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign pop = o_valid && i_ready;

    // Setting wins over clearing so a drop in the clear cycle is never lost.
    always_comb begin
        overflow_d = overflow_q;
        if (push && fifoFull && !pop) begin
            overflow_d = 1'b1;
        end else if (i_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rxMeta_q   <= 1'b1;
            rxSync_q   <= 1'b1;
            cnt_q      <= '0;
            idx_q      <= '0;
            shift_q    <= '0;
            frameErr_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            rxMeta_q   <= i_rx;
            rxSync_q   <= rxMeta_q;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            shift_q    <= shift_d;
            frameErr_q <= frameErr_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .data_i  (shift_q),
        .pop_i   (pop),
        .data_o  (o_data),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty),
        .count_o (o_count)
    );

    assign o_valid     = !fifoEmpty;
    assign o_frame_err = frameErr_q;
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_monitor.sv
// Directed bench for uart_tx_monitor: drives 8N1 frames at 108 clocks per bit
// and checks the popped byte stream, error pulses and FIFO flags.
module tb_uart_tx_monitor;

    localparam int BIT = 108;

    logic       clk;
    logic       rstn;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic       o_frame_err;
    logic       o_overflow;
    logic       i_clr;
    logic [4:0] o_count;

    int         compareCount;
    int         mismatchCount;
    int         errPulses;
    logic [7:0] rxQ [$];

    uart_tx_monitor dut (
        .clk         (clk),
        .rstn        (rstn),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_frame_err (o_frame_err),
        .o_overflow  (o_overflow),
        .i_clr       (i_clr),
        .o_count     (o_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change just after rising edges, so the falling edge sees settled values.
    always @(negedge clk) begin
        if (o_valid && i_ready) begin
            rxQ.push_back(o_data);
        end
        if (o_frame_err) begin
            errPulses++;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic stopBit);
        @(posedge clk);
        #1 i_rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 i_rx = data[i];
            repeat (BIT) @(posedge clk);
        end
        #1 i_rx = stopBit;
        repeat (BIT) @(posedge clk);
        #1 i_rx = 1'b1;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        compareCount  = 0;
        mismatchCount = 0;
        errPulses     = 0;
        rstn    = 1'b0;
        i_rx    = 1'b1;
        i_ready = 1'b0;
        i_clr   = 1'b0;

        repeat (5) @(negedge clk);
        checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("rst_data", {24'd0, o_data}, 32'd0);
        checkOutput("rst_count", {27'd0, o_count}, 32'd0);
        checkOutput("rst_ferr", {31'd0, o_frame_err}, 32'd0);
        checkOutput("rst_ovf", {31'd0, o_overflow}, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        idleCycles(20);

        $display("[TB] test 1: 0x55 then 0xA5");
        i_ready = 1'b1;
        rxQ.delete();
        errPulses = 0;
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'hA5, 1'b1);
        idleCycles(50);
        checkOutput("t1_n", rxQ.size(), 32'd2);
        checkOutput("t1_b0", {24'd0, rxQ[0]}, 32'h55);
        checkOutput("t1_b1", {24'd0, rxQ[1]}, 32'hA5);
        checkOutput("t1_ferr", errPulses, 32'd0);

        $display("[TB] test 2: 20-cycle glitch");
        rxQ.delete();
        #0 i_rx = 1'b0;
        idleCycles(20);
        i_rx = 1'b1;
        idleCycles(300);
        checkOutput("t2_count", {27'd0, o_count}, 32'd0);
        checkOutput("t2_n", rxQ.size(), 32'd0);
        checkOutput("t2_ferr", errPulses, 32'd0);

        $display("[TB] test 3: bad stop bit then 0x12");
        applyStimulus(8'h3C, 1'b0);
        idleCycles(2 * BIT);
        checkOutput("t3_ferr", errPulses, 32'd1);
        checkOutput("t3_count", {27'd0, o_count}, 32'd0);
        checkOutput("t3_n0", rxQ.size(), 32'd0);
        applyStimulus(8'h12, 1'b1);
        idleCycles(50);
        checkOutput("t3_n1", rxQ.size(), 32'd1);
        checkOutput("t3_b0", {24'd0, rxQ[0]}, 32'h12);
        checkOutput("t3_ferr2", errPulses, 32'd1);

        $display("[TB] test 4: overflow");
        i_ready = 1'b0;
        rxQ.delete();
        for (int b = 0; b < 17; b++) begin
            applyStimulus(8'(b), 1'b1);
            if (b == 15) begin
                idleCycles(20);
                checkOutput("t4_ovf_pre", {31'd0, o_overflow}, 32'd0);
            end
        end
        idleCycles(20);
        checkOutput("t4_count", {27'd0, o_count}, 32'd16);
        checkOutput("t4_ovf", {31'd0, o_overflow}, 32'd1);
        checkOutput("t4_head", {24'd0, o_data}, 32'h00);
        i_ready = 1'b1;
        idleCycles(30);
        i_ready = 1'b0;
        checkOutput("t4_n", rxQ.size(), 32'd16);
        for (int b = 0; b < 16; b++) begin
            checkOutput($sformatf("t4_b%0d", b), {24'd0, rxQ[b]}, b);
        end
        checkOutput("t4_empty", {27'd0, o_count}, 32'd0);
        checkOutput("t4_sticky", {31'd0, o_overflow}, 32'd1);
        i_clr = 1'b1;
        idleCycles(1);
        i_clr = 1'b0;
        idleCycles(2);
        checkOutput("t4_clr", {31'd0, o_overflow}, 32'd0);

        $display("[TB] test 5: pop in the stop-sample cycle");
        rxQ.delete();
        for (int b = 0; b < 16; b++) begin
            applyStimulus(8'h60 + 8'(b), 1'b1);
        end
        idleCycles(20);
        checkOutput("t5_full", {27'd0, o_count}, 32'd16);
        @(negedge clk);
        fork
            applyStimulus(8'h77, 1'b1);
            begin
                // 2 sync + 54 half-bit + 8 data bits + 107 counts into the stop bit.
                repeat (1029) @(posedge clk);
                #1 i_ready = 1'b1;
                @(posedge clk);
                #1 i_ready = 1'b0;
            end
        join
        idleCycles(20);
        checkOutput("t5_count", {27'd0, o_count}, 32'd16);
        checkOutput("t5_ovf", {31'd0, o_overflow}, 32'd0);
        checkOutput("t5_pop1", rxQ.size(), 32'd1);
        i_ready = 1'b1;
        idleCycles(30);
        checkOutput("t5_n", rxQ.size(), 32'd17);
        checkOutput("t5_first", {24'd0, rxQ[0]}, 32'h60);
        checkOutput("t5_b15", {24'd0, rxQ[15]}, 32'h6F);
        checkOutput("t5_last", {24'd0, rxQ[16]}, 32'h77);

        $display("[TB] test 6: reset mid-frame");
        i_ready = 1'b0;
        applyStimulus(8'h5A, 1'b1);
        idleCycles(20);
        checkOutput("t6_pre", {27'd0, o_count}, 32'd1);
        rxQ.delete();
        @(negedge clk);
        fork
            applyStimulus(8'h99, 1'b1);
            begin
                repeat (595) @(posedge clk);
                #1 rstn = 1'b0;
                repeat (3) @(negedge clk);
                checkOutput("t6_rst_valid", {31'd0, o_valid}, 32'd0);
                checkOutput("t6_rst_count", {27'd0, o_count}, 32'd0);
                checkOutput("t6_rst_data", {24'd0, o_data}, 32'd0);
                checkOutput("t6_rst_ferr", {31'd0, o_frame_err}, 32'd0);
                checkOutput("t6_rst_ovf", {31'd0, o_overflow}, 32'd0);
                repeat (500) @(posedge clk);
                #1 rstn = 1'b1;
            end
        join
        idleCycles(50);
        i_ready = 1'b1;
        applyStimulus(8'h42, 1'b1);
        idleCycles(50);
        checkOutput("t6_n", rxQ.size(), 32'd1);
        checkOutput("t6_b0", {24'd0, rxQ[0]}, 32'h42);
        checkOutput("t6_ferr", errPulses, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
